button_conditioner: RTL

Conditions the raw, asynchronous push-button input before it reaches the LED control logic in `top`. The block synchronises `button`, debounces it, and classifies each press. It outputs a clean level plus single-cycle press, release, short-press and long-press events. It sits between the `button` pin and the colour/state logic that drives `red`, `green` and `blue`.

---
 rtl/button_conditioner.sv | 121 ++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Push-button front end: synchronises and debounces the raw pin, then
// classifies each debounced press into press/release/short/long strobes.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES   = 4,
   parameter int LONG_PRESS_CYCLES = 16,
   parameter bit ACTIVE_HIGH       = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic button,
   output logic pressed,
   output logic press_pulse,
   output logic release_pulse,
   output logic short_pulse,
   output logic long_pulse
);

   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
   localparam logic              POL_FLIP  = ~ACTIVE_HIGH;

   typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;

   logic              sync1, sync2;
   logic [DB_W-1:0]   db_cnt;
   logic              differs, flip, rise, fall;
   state_t            state, state_next;
   logic [HOLD_W-1:0] hold_cnt, hold_next;
   logic              press_next, release_next, short_next, long_next;

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= button ^ POL_FLIP;
         sync2 <= sync1;
      end
   end

   // The level flips on the edge that would complete the run of disagreements,
   // so rise/fall are visible to the press FSM in that same cycle.
   assign differs = sync2 ^ pressed;
   assign flip    = differs && (db_cnt == DB_LAST);
   assign rise    = flip && !pressed;
   assign fall    = flip && pressed;

   always_ff @(posedge clk) begin
      if (!reset) begin
         pressed <= 1'b0;
         db_cnt  <= '0;
      end else if (flip) begin
         pressed <= ~pressed;
         db_cnt  <= '0;
      end else if (differs) begin
         db_cnt  <= db_cnt + DB_W'(1);
      end else begin
         db_cnt  <= '0;
      end
   end

   always_comb begin
      state_next   = state;
      hold_next    = hold_cnt;
      press_next   = 1'b0;
      release_next = 1'b0;
      short_next   = 1'b0;
      long_next    = 1'b0;
      case (state)
         IDLE: begin
            if (rise) begin
               state_next = HELD;
               hold_next  = '0;
               press_next = 1'b1;
            end
         end
         HELD: begin
            // A release coinciding with the long threshold counts as short.
            if (fall) begin
               state_next   = IDLE;
               release_next = 1'b1;
               short_next   = 1'b1;
            end else if (hold_cnt == HOLD_LAST) begin
               state_next = LONG;
               hold_next  = hold_cnt + HOLD_W'(1);
               long_next  = 1'b1;
            end else begin
               hold_next  = hold_cnt + HOLD_W'(1);
            end
         end
         LONG: begin
            if (fall) begin
               state_next   = IDLE;
               release_next = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= IDLE;
         hold_cnt      <= '0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         short_pulse   <= 1'b0;
         long_pulse    <= 1'b0;
      end else begin
         state         <= state_next;
         hold_cnt      <= hold_next;
         press_pulse   <= press_next;
         release_pulse <= release_next;
         short_pulse   <= short_next;
         long_pulse    <= long_next;
      end
   end

endmodule
